// File: rtl/sm_divider.sv
// sm_divider: sequential sign-magnitude restoring divider.
// Divides a 2*SIZE-bit sign-magnitude dividend (multiplier product format)
// by a SIZE-bit sign-magnitude divisor, producing one quotient bit per clock.
// Results are a SIZE-bit sign-magnitude quotient and remainder, plus
// overflow (quotient does not fit) and divide-by-zero flags.
module sm_divider #(
    parameter int SIZE = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2*SIZE-1:0] a,
    input  logic [SIZE-1:0]   b,
    output logic              busy,
    output logic              done,
    output logic [SIZE-1:0]   q,
    output logic [SIZE-1:0]   r,
    output logic              ovf,
    output logic              dz
);

    // Magnitude width and iteration-counter width.
    localparam int MW = SIZE - 1;
    localparam int CW = $clog2(SIZE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_CALC,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    // Latched operands, so a and b may change after the start edge.
    logic [2*SIZE-1:0] a_q, a_d;
    logic [SIZE-1:0]   b_q, b_d;

    // Partial remainder (always < divisor, so MW bits suffice), dividend
    // low-bit shift register that fills with quotient bits, iteration count.
    logic [MW-1:0]     p_q, p_d;
    logic [MW-1:0]     sh_q, sh_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    // Registered results; they hold until the next completion.
    logic [SIZE-1:0]   q_q, q_d;
    logic [SIZE-1:0]   r_q, r_d;
    logic              ovf_q, ovf_d;
    logic              dz_q, dz_d;

    // Views of the latched operands.
    logic [SIZE-1:0]   hi;
    logic [MW-1:0]     lo;
    logic [SIZE-1:0]   mag_b;
    logic              b_zero;
    logic              hi_ge_b;
    logic              sign_q;
    logic              sign_r;

    // One restoring-division step.
    logic [SIZE-1:0]   trial;
    logic              qbit;
    logic [MW-1:0]     p_next;
    logic [MW-1:0]     q_next_mag;
    logic              last_iter;

    // Operand decode and the restoring step used by CHECK and CALC.
    always_comb begin
        hi         = a_q[2*SIZE-2:MW];
        lo         = a_q[MW-1:0];
        mag_b      = {1'b0, b_q[MW-1:0]};
        b_zero     = (b_q[MW-1:0] == '0);
        // HI >= B means the quotient needs at least SIZE magnitude bits.
        hi_ge_b    = (hi >= mag_b);
        sign_q     = a_q[2*SIZE-1] ^ b_q[SIZE-1];
        sign_r     = a_q[2*SIZE-1];

        trial      = {p_q, sh_q[MW-1]};
        qbit       = (trial >= mag_b);
        p_next     = qbit ? MW'(trial - mag_b) : trial[MW-1:0];
        q_next_mag = {sh_q[MW-2:0], qbit};
        last_iter  = (cnt_q == CW'(1));
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: sequential state always uses non-blocking assignment so every
            // flop samples its pre-edge inputs, independent of statement order.
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first, so every path assigns state_d and no latch forms.
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_CHECK;
            S_CHECK: state_d = (b_zero || hi_ge_b) ? S_DONE : S_CALC;
            S_CALC:  if (last_iter) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs decoded from state.
    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    // Datapath next values: operand latch, division steps, result write-back.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        p_d   = p_q;
        sh_d  = sh_q;
        cnt_d = cnt_q;
        q_d   = q_q;
        r_d   = r_q;
        ovf_d = ovf_q;
        dz_d  = dz_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d = a;
                    b_d = b;
                end
            end
            S_CHECK: begin
                if (b_zero) begin
                    dz_d  = 1'b1;
                    ovf_d = 1'b0;
                    q_d   = '0;
                    r_d   = '0;
                end else if (hi_ge_b) begin
                    dz_d  = 1'b0;
                    ovf_d = 1'b1;
                    q_d   = '0;
                    r_d   = '0;
                end else begin
                    // HI < B here, so its top bit is zero.
                    p_d   = hi[MW-1:0];
                    sh_d  = lo;
                    cnt_d = CW'(MW);
                end
            end
            S_CALC: begin
                p_d   = p_next;
                sh_d  = q_next_mag;
                cnt_d = cnt_q - 1'b1;
                if (last_iter) begin
                    // Zero magnitudes always carry a positive sign.
                    q_d   = {sign_q && (q_next_mag != '0), q_next_mag};
                    r_d   = {sign_r && (p_next != '0), p_next};
                    ovf_d = 1'b0;
                    dz_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset clears operands, working state and results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            p_q   <= '0;
            sh_q  <= '0;
            cnt_q <= '0;
            q_q   <= '0;
            r_q   <= '0;
            ovf_q <= 1'b0;
            dz_q  <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            p_q   <= p_d;
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
            q_q   <= q_d;
            r_q   <= r_d;
            ovf_q <= ovf_d;
            dz_q  <= dz_d;
        end
    end

    // Result ports.
    always_comb begin
        q   = q_q;
        r   = r_q;
        ovf = ovf_q;
        dz  = dz_q;
    end

endmodule

// File: tb/tb_sm_divider.sv
// tb_sm_divider: directed and random checks of sm_divider against an
// arithmetic reference model (integer divide / modulo on magnitudes).
module tb_sm_divider;

    localparam int SIZE = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [2*SIZE-1:0] a;
    logic [SIZE-1:0]   b;
    logic              busy;
    logic              done;
    logic [SIZE-1:0]   q;
    logic [SIZE-1:0]   r;
    logic              ovf;
    logic              dz;

    int total = 0;
    int bad   = 0;

    logic [SIZE-1:0] prev_q = '0;
    logic [SIZE-1:0] prev_r = '0;

    sm_divider #(.SIZE(SIZE)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .q     (q),
        .r     (r),
        .ovf   (ovf),
        .dz    (dz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: truncating signed division on magnitudes, errors first.
    function automatic void model(input logic [15:0] av, input logic [7:0] bv,
                                  output logic [7:0] eq, output logic [7:0] er,
                                  output logic eovf, output logic edz, output int lat);
        int am;
        int bm;
        int qm;
        int rm;
        am   = int'(av[14:0]);
        bm   = int'(bv[6:0]);
        eq   = '0;
        er   = '0;
        eovf = 1'b0;
        edz  = 1'b0;
        if (bm == 0) begin
            edz = 1'b1;
            lat = 1;
        end else if (am / bm > 127) begin
            eovf = 1'b1;
            lat  = 1;
        end else begin
            qm  = am / bm;
            rm  = am % bm;
            eq  = {(qm != 0) && (av[15] ^ bv[7]), 7'(qm)};
            er  = {(rm != 0) && av[15], 7'(rm)};
            lat = SIZE;
        end
    endfunction

    // One operation from a start pulse to the cycle after done.
    task automatic run_op(input logic [15:0] av, input logic [7:0] bv, input bit poke);
        logic [7:0] eq;
        logic [7:0] er;
        logic       eovf;
        logic       edz;
        int         lat;
        int         cyc;
        model(av, bv, eq, er, eovf, edz, lat);
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 16'($urandom);
        b     = 8'($urandom);
        check("busy_e0", 32'(busy), 32'(1));
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            check("hold_q", 32'(q), 32'(prev_q));
            check("hold_r", 32'(r), 32'(prev_r));
            start = (poke && lat == SIZE && cyc == 2);
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        check("latency", 32'(cyc), 32'(lat));
        check("q", 32'(q), 32'(eq));
        check("r", 32'(r), 32'(er));
        check("ovf", 32'(ovf), 32'(eovf));
        check("dz", 32'(dz), 32'(edz));
        prev_q = eq;
        prev_r = er;
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(done), 32'(0));
        check("idle_after_done", 32'(busy), 32'(0));
        if (poke && lat == SIZE) begin
            for (int i = 0; i < SIZE + 2; i++) begin
                @(posedge clk);
                #1;
                check("no_extra_done", 32'({busy, done}), 32'(0));
            end
        end
    endtask

    initial begin
        int bm;
        int am;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #12;
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_q", 32'(q), 32'(0));
        check("rst_r", 32'(r), 32'(0));
        check("rst_ovf", 32'(ovf), 32'(0));
        check("rst_dz", 32'(dz), 32'(0));
        @(negedge clk);
        rst = 1'b0;

        // Sign combinations of 100 / 7.
        run_op(16'h0064, 8'h07, 1'b0);
        check("tp_q_pp", 32'(q), 32'h0E);
        check("tp_r_pp", 32'(r), 32'h02);
        run_op(16'h8064, 8'h07, 1'b0);
        check("tp_q_np", 32'(q), 32'h8E);
        check("tp_r_np", 32'(r), 32'h82);
        run_op(16'h0064, 8'h87, 1'b0);
        run_op(16'h8064, 8'h87, 1'b0);
        // Largest in-range quotient, then the errors and HI==B boundary.
        run_op(16'h3F7F, 8'h7F, 1'b0);
        check("tp_q_max", 32'(q), 32'h7F);
        run_op(16'h1234, 8'h80, 1'b0);
        check("tp_dz", 32'(dz), 32'(1));
        run_op(16'h4000, 8'h01, 1'b0);
        run_op(16'h3F80, 8'h7F, 1'b0);
        check("tp_ovf_bound", 32'(ovf), 32'(1));
        // Zero quotient with negative operands stays positive zero.
        run_op(16'h8003, 8'h85, 1'b0);
        check("tp_q_zero", 32'(q), 32'h00);
        check("tp_r_neg", 32'(r), 32'h83);
        // Start pulsed while busy is ignored.
        run_op(16'h0064, 8'h07, 1'b1);

        // Reset in the middle of an operation.
        @(negedge clk);
        a     = 16'h8064;
        b     = 8'h07;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_done", 32'(done), 32'(0));
        check("abort_q", 32'(q), 32'(0));
        check("abort_r", 32'(r), 32'(0));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("abort_no_done", 32'(done), 32'(0));
        end
        @(negedge clk);
        rst    = 1'b0;
        prev_q = '0;
        prev_r = '0;
        for (int i = 0; i < SIZE + 2; i++) begin
            @(posedge clk);
            #1;
            check("post_rst_quiet", 32'({busy, done}), 32'(0));
        end
        run_op(16'h0064, 8'h07, 1'b0);
        check("post_rst_q", 32'(q), 32'h0E);
        check("post_rst_r", 32'(r), 32'h02);

        // Random operations, mostly constructed to stay in range.
        for (int i = 0; i < 30; i++) begin
            bm = (i % 10 == 9) ? 0 : int'($urandom_range(1, 127));
            if ($urandom_range(0, 3) == 0) begin
                am = int'($urandom_range(0, 32767));
            end else begin
                am = int'($urandom_range(0, 127)) * bm +
                     ((bm > 0) ? int'($urandom_range(0, bm - 1)) : 0);
            end
            run_op({1'($urandom), 15'(am)}, {1'($urandom), 7'(bm)}, (i % 7) == 3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
